// File: rtl/pipeline_hazard_sequencer.sv
// Purpose : sequences pipeline flushes (redirects) and per-stage stalls for a
//           five-stage pipeline. Flush has priority over stall, and an accepted
//           redirect holds flush high for FLUSH_CYCLES cycles.
// Ports   : clk/rst (async, active-high); exStallReq/maStallReq stall requests;
//           flushReq/flushPc redirect request; nextPc/flush registered redirect;
//           ifStall..bypassStall combinational stalls; stallCycles/flushCount stats.
module pipeline_hazard_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h8000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exStallReq,
  input  logic        maStallReq,
  input  logic        flushReq,
  input  logic [31:0] flushPc,
  output logic [31:0] nextPc,
  output logic        flush,
  output logic        ifStall,
  output logic        idStall,
  output logic        rrStall,
  output logic        exStall,
  output logic        bypassStall,
  output logic [31:0] stallCycles,
  output logic [15:0] flushCount
);

  typedef enum logic {
    IDLE     = 1'b0,
    FLUSHING = 1'b1
  } state_t;

  // Counter reload: flush is already high for the first cycle when the
  // counter holds FLUSH_CYCLES-1, so it covers the remaining cycles.
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic        flushing;
  logic        stall_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      flush_cnt_q    <= 4'd0;
      next_pc_q      <= RESET_PC;
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      next_pc_q      <= next_pc_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Next-state: a redirect request is accepted in either state and always
  // restarts the flush window; otherwise the window counts down to IDLE.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    next_pc_d     = next_pc_q;
    flush_count_d = flush_count_q;
    if (flushReq) begin
      state_d       = FLUSHING;
      flush_cnt_d   = FLUSH_RELOAD;
      next_pc_d     = flushPc;
      flush_count_d = flush_count_q + 16'd1;
    end else if (state_q == FLUSHING) begin
      if (flush_cnt_q != 4'd0) begin
        flush_cnt_d = flush_cnt_q - 4'd1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Stalls come straight from the requests; while flushing they are masked
  // because the stages are being squashed anyway.
  assign flushing  = (state_q == FLUSHING);
  assign stall_any = exStallReq | maStallReq;

  always_comb begin
    ifStall     = stall_any & ~flushing;
    idStall     = stall_any & ~flushing;
    rrStall     = stall_any & ~flushing;
    bypassStall = stall_any & ~flushing;
    exStall     = maStallReq & ~flushing;
  end

  // Saturating count of fetch-stall cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (ifStall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  assign flush       = flushing;
  assign nextPc      = next_pc_q;
  assign stallCycles = stall_cycles_q;
  assign flushCount  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
module tb_pipeline_hazard_sequencer;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        exStallReq, maStallReq, flushReq;
  logic [31:0] flushPc;
  logic [31:0] nextPc, stallCycles;
  logic        flush, ifStall, idStall, rrStall, exStall, bypassStall;
  logic [15:0] flushCount;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_sequencer dut (
    .clk(clk), .rst(rst),
    .exStallReq(exStallReq), .maStallReq(maStallReq),
    .flushReq(flushReq), .flushPc(flushPc),
    .nextPc(nextPc), .flush(flush),
    .ifStall(ifStall), .idStall(idStall), .rrStall(rrStall),
    .exStall(exStall), .bypassStall(bypassStall),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the flush window is "cycles of flush still owed";
  // a redirect resets it to FLUSH_CYCLES, each other edge pays one off.
  int          m_rem;
  logic [31:0] m_pc;
  logic [15:0] m_fc;
  logic [31:0] m_sc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0;
      m_pc  = 32'h8000_0000;
      m_fc  = 16'd0;
      m_sc  = 32'd0;
    end else begin
      if (m_rem == 0 && (exStallReq || maStallReq) && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
      if (flushReq) begin
        m_rem = FC;
        m_pc  = flushPc;
        m_fc  = m_fc + 16'd1;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    logic e_fl, e_st, e_ex;
    e_fl = (m_rem > 0);
    e_st = (exStallReq | maStallReq) & ~e_fl;
    e_ex = maStallReq & ~e_fl;
    chk("m_flush",       32'(flush),       32'(e_fl));
    chk("m_nextPc",      nextPc,           m_pc);
    chk("m_ifStall",     32'(ifStall),     32'(e_st));
    chk("m_idStall",     32'(idStall),     32'(e_st));
    chk("m_rrStall",     32'(rrStall),     32'(e_st));
    chk("m_bypassStall", 32'(bypassStall), 32'(e_st));
    chk("m_exStall",     32'(exStall),     32'(e_ex));
    chk("m_stallCycles", stallCycles,      m_sc);
    chk("m_flushCount",  32'(flushCount),  32'(m_fc));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; exStallReq = 1'b0; maStallReq = 1'b0; flushReq = 1'b0; flushPc = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // Reset release, idle
    chk("rst_flush",   32'(flush), 32'd0);
    chk("rst_nextPc",  nextPc, 32'h8000_0000);
    chk("rst_ifStall", 32'(ifStall), 32'd0);
    chk("rst_exStall", 32'(exStall), 32'd0);
    chk("rst_stallCycles", stallCycles, 32'd0);
    chk("rst_flushCount", 32'(flushCount), 32'd0);

    // exStallReq for 3 cycles
    tick();
    for (int i = 0; i < 3; i++) begin
      exStallReq = 1'b1;
      #1;
      chk("ex3_ifStall", 32'(ifStall), 32'd1);
      chk("ex3_bypassStall", 32'(bypassStall), 32'd1);
      chk("ex3_exStall", 32'(exStall), 32'd0);
      tick();
    end
    exStallReq = 1'b0;
    #1;
    chk("ex3_stallCycles", stallCycles, 32'd3);

    // Single redirect, FLUSH_CYCLES=2
    tick();
    flushReq = 1'b1; flushPc = 32'h0000_1000;
    tick();
    flushReq = 1'b0;
    chk("f1_flush_c1", 32'(flush), 32'd1);
    chk("f1_nextPc", nextPc, 32'h0000_1000);
    chk("f1_flushCount", 32'(flushCount), 32'd1);
    tick();
    chk("f1_flush_c2", 32'(flush), 32'd1);
    tick();
    chk("f1_flush_c3", 32'(flush), 32'd0);
    chk("f1_nextPc_hold", nextPc, 32'h0000_1000);

    // Back-to-back redirects
    pulse_rst();
    flushReq = 1'b1; flushPc = 32'h100;
    tick();
    chk("f2_flush_c1", 32'(flush), 32'd1);
    chk("f2_nextPc_a", nextPc, 32'h100);
    flushPc = 32'h200;
    tick();
    flushReq = 1'b0;
    chk("f2_flush_c2", 32'(flush), 32'd1);
    chk("f2_nextPc_b", nextPc, 32'h200);
    tick();
    chk("f2_flush_c3", 32'(flush), 32'd1);
    tick();
    chk("f2_flush_c4", 32'(flush), 32'd0);
    chk("f2_flushCount", 32'(flushCount), 32'd2);

    // Flush masks stall; simultaneous request with stall while idle
    tick();
    maStallReq = 1'b1; flushReq = 1'b1; flushPc = 32'h4000;
    #1;
    chk("ms_same_ifStall", 32'(ifStall), 32'd1);
    chk("ms_same_exStall", 32'(exStall), 32'd1);
    tick();
    flushReq = 1'b0;
    #1;
    chk("ms_fl_ifStall", 32'(ifStall), 32'd0);
    chk("ms_fl_exStall", 32'(exStall), 32'd0);
    tick();
    chk("ms_fl2_rrStall", 32'(rrStall), 32'd0);
    tick();
    chk("ms_after_flush", 32'(flush), 32'd0);
    chk("ms_after_ifStall", 32'(ifStall), 32'd1);
    chk("ms_after_exStall", 32'(exStall), 32'd1);
    chk("ms_after_idStall", 32'(idStall), 32'd1);
    maStallReq = 1'b0;

    // Reset mid-flush, checked before the next edge
    tick();
    flushReq = 1'b1; flushPc = 32'h0000_0ABC;
    tick();
    flushReq = 1'b0;
    chk("rm_flush_pre", 32'(flush), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rm_flush", 32'(flush), 32'd0);
    chk("rm_nextPc", nextPc, 32'h8000_0000);
    chk("rm_flushCount", 32'(flushCount), 32'd0);
    rst = 1'b0;
    tick();
    chk("rm_idle_after", 32'(flush), 32'd0);

    // 2^16 accepted redirects wrap the counter
    flushReq = 1'b1; flushPc = 32'h0000_2000;
    for (int i = 0; i < 65535; i++) tick();
    chk("wrap_ffff", 32'(flushCount), 32'h0000_FFFF);
    tick();
    chk("wrap_zero", 32'(flushCount), 32'd0);
    chk("wrap_flush", 32'(flush), 32'd1);
    flushReq = 1'b0;
    tick(); tick(); tick();
    chk("wrap_flush_end", 32'(flush), 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_sequencer.md
PIPELINE_HAZARD_SEQUENCER -- requirements
Module: pipeline_hazard_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, value loaded into nextPc on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of consecutive cycles flush is held high per redirect; legal range 1..15.
REQ-003 Port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port exStallReq  in  1  execute stage needs more cycles (multi-cycle op).
REQ-006 Port maStallReq  in  1  memory-access stage waiting on memory.
REQ-007 Port flushReq  in  1  memory-access stage requests pipeline redirect.
REQ-008 Port flushPc  in  32  redirect target, valid when flushReq=1.
REQ-009 Port nextPc  out  32  registered redirect target for the fetch unit.
REQ-010 Port flush  out  1  registered flush strobe to all stages.
REQ-011 Ports ifStall, idStall, rrStall, exStall, bypassStall  out  1 each  per-stage stall.
REQ-012 Port stallCycles  out  32  count of cycles with ifStall=1, saturating.
REQ-013 Port flushCount  out  16  count of accepted redirects, wrapping.

Function
REQ-014 FSM has two states, IDLE and FLUSHING, plus a 4-bit down-counter flushCnt.
REQ-015 IDLE + flushReq=1: next cycle state=FLUSHING, flush=1, nextPc=flushPc, flushCnt=FLUSH_CYCLES-1; latency from flushReq to flush is exactly 1 cycle.
REQ-016 FLUSHING, flushReq=0, flushCnt>0: flushCnt decrements, flush stays 1.
REQ-017 FLUSHING, flushReq=0, flushCnt=0: next cycle state=IDLE, flush=0.
REQ-018 FLUSHING + flushReq=1: nextPc re-latched to new flushPc, flushCnt reloaded to FLUSH_CYCLES-1, flush stays 1 (restart; no gap).
REQ-019 nextPc changes only on an accepted flushReq or reset; held otherwise.
REQ-020 Stalls are combinational from current inputs and state, no added latency.
REQ-021 exStall = maStallReq.
REQ-022 ifStall = idStall = rrStall = bypassStall = exStallReq | maStallReq.
REQ-023 While flush=1 (state FLUSHING), all five stall outputs are forced 0; flush has priority over stall.
REQ-024 flushReq sampled regardless of stall requests; simultaneous flushReq and stall requests: flush accepted, stalls obey REQ-021/022 for the current cycle.
REQ-025 stallCycles increments by 1 each cycle ifStall=1; holds at 32'hFFFF_FFFF.
REQ-026 flushCount increments by 1 per accepted flushReq (including restarts in FLUSHING); wraps 16'hFFFF -> 0.
REQ-027 No combinational path from flushReq or flushPc to any output.

Reset
REQ-028 rst=1 asynchronously forces state=IDLE, flushCnt=0, flush=0, nextPc=RESET_PC, stallCycles=0, flushCount=0, independent of clk.
REQ-029 Reset asserted mid-FLUSHING aborts the flush immediately; after rst deasserts, first edge behaves as IDLE.
REQ-030 Stall outputs during reset follow REQ-021/022 from inputs (state is IDLE).

Verification
REQ-031 Reset release, all requests 0 -> flush=0, all stalls 0, nextPc=32'h8000_0000, counters 0.
REQ-032 exStallReq=1 for 3 cycles -> ifStall/idStall/rrStall/bypassStall=1, exStall=0 those 3 cycles; stallCycles=3.
REQ-033 flushReq=1 one cycle with flushPc=32'h0000_1000, FLUSH_CYCLES=2 -> flush=1 exactly cycles +1 and +2, nextPc=32'h0000_1000 from +1, flushCount=1.
REQ-034 flushReq pc=32'h100 then again 1 cycle later pc=32'h200 -> flush high 3 consecutive cycles, nextPc=32'h200 from second acceptance, flushCount=2.
REQ-035 maStallReq=1 held during FLUSHING -> all stalls 0 while flush=1, all stalls 1 first cycle after flush drops.
REQ-036 rst pulsed mid-flush (between clock edges) -> flush=0 and nextPc=RESET_PC before next edge; 2^16 accepted flushes -> flushCount wraps to 0.
